score_keeper: RTL



---
 rtl/score_pkg.sv | 37 +++
 rtl/score_keeper_bcd_add3.sv | 49 ++++
 rtl/score_keeper.sv | 136 +++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// score_pkg
// Shared definitions for the score_keeper round controller:
//   - state_e       : FSM state encodings (IDLE/PLAYING/OVER; code 2'd3 is illegal)
//   - BCD_W/NDIGITS : digit width and number of score digits
//   - MAX_SCORE_BCD : saturation value of the 3-digit BCD score
//   - bcd_gt()      : magnitude compare of two packed BCD values, MSB digit first
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_OVER    = 2'd2
  } state_e;

  localparam int          BCD_W         = 4;
  localparam int          NDIGITS       = 3;
  localparam logic [11:0] MAX_SCORE_BCD = 12'h999;

  // True when a > b. The first digit that differs, scanning from the
  // hundreds digit down, decides the result.
  function automatic logic bcd_gt(input logic [11:0] a, input logic [11:0] b);
    logic decided;
    logic result;
    decided = 1'b0;
    result  = 1'b0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[i*BCD_W +: BCD_W] != b[i*BCD_W +: BCD_W])) begin
        decided = 1'b1;
        result  = (a[i*BCD_W +: BCD_W] > b[i*BCD_W +: BCD_W]);
      end else begin
        decided = decided;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/score_keeper_bcd_add3.sv
// bcd_add3
// Combinational 3-digit BCD adder: sum_bcd = a_bcd + inc_bcd, saturating at 999.
// Ports:
//   a_bcd   in  12  {hundreds, tens, ones} operand
//   inc_bcd in   4  single BCD digit added to the ones position
//   sum_bcd out 12  BCD result, clamped to 999 on overflow
module bcd_add3
  import score_pkg::*;
(
  input  logic [11:0] a_bcd,
  input  logic [3:0]  inc_bcd,
  output logic [11:0] sum_bcd
);

  logic [11:0] raw_s;
  logic [4:0]  dsum_s;
  logic [4:0]  dadj_s;
  logic        carry_s;

  // Digit-serial ripple add; a carry out of the hundreds digit means overflow.
  always_comb begin
    raw_s   = 12'h000;
    dsum_s  = 5'd0;
    dadj_s  = 5'd0;
    carry_s = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      dsum_s = {1'b0, a_bcd[i*BCD_W +: BCD_W]} + {4'd0, carry_s};
      if (i == 0) begin
        dsum_s = dsum_s + {1'b0, inc_bcd};
      end else begin
        dsum_s = dsum_s;
      end
      if (dsum_s > 5'd9) begin
        dadj_s  = dsum_s - 5'd10;
        carry_s = 1'b1;
      end else begin
        dadj_s  = dsum_s;
        carry_s = 1'b0;
      end
      raw_s[i*BCD_W +: BCD_W] = dadj_s[3:0];
    end
    if (carry_s) begin
      sum_bcd = MAX_SCORE_BCD;
    end else begin
      sum_bcd = raw_s;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// score_keeper
// Round/score controller downstream of the 1-minute countdown timer.
// Ports:
//   CLOCK_50      in   1  system clock
//   reset         in   1  synchronous, active-high reset
//   start         in   1  level; rising edge starts a round
//   hit           in   1  level; rising edge is one player hit
//   timer_done    in   1  level from countdown timer; rising edge ends the round
//   timer_restart out  1  one-cycle pulse asking the timer to reload 1:00
//   score_bcd     out 12  current score, {hundreds, tens, ones}
//   high_bcd      out 12  best score since reset, {hundreds, tens, ones}
//   playing       out  1  high while in PLAYING
//   game_over     out  1  high while in OVER
// All outputs are registered; there is no combinational input-to-output path.
module score_keeper
  import score_pkg::*;
#(
  parameter logic [3:0] POINTS_PER_HIT = 4'd1,
  parameter int         MAX_SCORE      = 999
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        hit,
  input  logic        timer_done,
  output logic        timer_restart,
  output logic [11:0] score_bcd,
  output logic [11:0] high_bcd,
  output logic        playing,
  output logic        game_over
);

  if ((POINTS_PER_HIT < 4'd1) || (POINTS_PER_HIT > 4'd9) || (MAX_SCORE != 999)) begin : g_param_bad
    $error("score_keeper: POINTS_PER_HIT must be 1..9 and MAX_SCORE must be 999");
  end

  state_e      state_q, state_d;
  logic [11:0] score_q, score_d;
  logic [11:0] high_q, high_d;
  logic        timer_restart_q, timer_restart_d;
  logic        playing_q, playing_d;
  logic        game_over_q, game_over_d;
  logic        start_prev_q, start_prev_d;
  logic        hit_prev_q, hit_prev_d;
  logic        done_prev_q, done_prev_d;

  logic        rise_start_s, rise_hit_s, rise_done_s;
  logic [11:0] sum_s;

  assign rise_start_s = start & ~start_prev_q;
  assign rise_hit_s   = hit & ~hit_prev_q;
  assign rise_done_s  = timer_done & ~done_prev_q;

  bcd_add3 u_add (
    .a_bcd   (score_q),
    .inc_bcd (POINTS_PER_HIT),
    .sum_bcd (sum_s)
  );

  // Next-state, score and high-score computation.
  always_comb begin
    state_d         = state_q;
    score_d         = score_q;
    high_d          = high_q;
    timer_restart_d = 1'b0;
    start_prev_d    = start;
    hit_prev_d      = hit;
    done_prev_d     = timer_done;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (rise_start_s) begin
          state_d         = ST_PLAYING;
          score_d         = 12'h000;
          timer_restart_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_PLAYING: begin
        if (rise_hit_s) begin
          score_d = sum_s;
        end else begin
          score_d = score_q;
        end
        // A hit in the same cycle is already folded into score_d here.
        if (rise_done_s) begin
          state_d = ST_OVER;
          if (bcd_gt(score_d, high_q)) begin
            high_d = score_d;
          end else begin
            high_d = high_q;
          end
        end else begin
          state_d = ST_PLAYING;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    playing_d   = (state_d == ST_PLAYING);
    game_over_d = (state_d == ST_OVER);
  end

  // State and output registers; edge history resets high so held inputs do not fire.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      score_q         <= 12'h000;
      high_q          <= 12'h000;
      timer_restart_q <= 1'b0;
      playing_q       <= 1'b0;
      game_over_q     <= 1'b0;
      start_prev_q    <= 1'b1;
      hit_prev_q      <= 1'b1;
      done_prev_q     <= 1'b1;
    end else begin
      state_q         <= state_d;
      score_q         <= score_d;
      high_q          <= high_d;
      timer_restart_q <= timer_restart_d;
      playing_q       <= playing_d;
      game_over_q     <= game_over_d;
      start_prev_q    <= start_prev_d;
      hit_prev_q      <= hit_prev_d;
      done_prev_q     <= done_prev_d;
    end
  end

  assign timer_restart = timer_restart_q;
  assign score_bcd     = score_q;
  assign high_bcd      = high_q;
  assign playing       = playing_q;
  assign game_over     = game_over_q;

endmodule
